// File: rtl/proc_fetch_unit.sv
// TinyRV1 fetch stage: owns the fetch PC, issues in-order imem requests under
// a two-credit scheme, buffers responses and drives the F/D pipeline register.
module proc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  c2d_pc_sel_F,
    input  logic        c2d_reg_en_F,
    input  logic [31:0] jr_target_D,
    input  logic [31:0] jal_target_D,
    input  logic [31:0] br_target_X,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_addr,
    input  logic        imemresp_val,
    input  logic [31:0] imemresp_data,
    output logic [31:0] inst_D,
    output logic [31:0] pc_D,
    output logic        inst_val_D
);

    logic [31:0] pc_F_q, pc_F_d;
    logic [1:0]  infl_q, infl_d;
    logic [1:0]  drop_q, drop_d;

    logic [31:0] pcq_mem_q [2];
    logic        pcq_wr_q, pcq_rd_q;

    logic [31:0] buf_inst_q [2];
    logic [31:0] buf_pc_q [2];
    logic        buf_wr_q, buf_rd_q;
    logic [1:0]  occ_q, occ_d;

    logic [31:0] inst_D_q, inst_D_d;
    logic [31:0] pc_D_q, pc_D_d;
    logic        val_D_q, val_D_d;

    logic        accept;
    logic        resp_ok;
    logic        resp_keep;
    logic [31:0] resp_pc;
    logic        redirect;
    logic        advance;
    logic        pop;
    logic        bypass;
    logic        push;

    // Credits cover both outstanding requests and buffered responses
    assign imemreq_val  = ~rst & (({1'b0, infl_q} + {1'b0, occ_q}) < 3'd2);
    assign imemreq_addr = pc_F_q;

    assign accept    = imemreq_val & imemreq_rdy;
    assign resp_ok   = imemresp_val & (infl_q != 2'd0);
    assign resp_keep = resp_ok & (drop_q == 2'd0);
    assign resp_pc   = pcq_mem_q[pcq_rd_q];

    assign redirect = (c2d_pc_sel_F != 2'd0);
    assign advance  = ~redirect & c2d_reg_en_F;
    assign pop      = advance & (occ_q != 2'd0);
    assign bypass   = advance & (occ_q == 2'd0) & resp_keep;
    assign push     = ~redirect & resp_keep & ~bypass;

    assign infl_d = infl_q + {1'b0, accept} - {1'b0, resp_ok};
    assign occ_d  = occ_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        drop_d = drop_q;
        if (redirect) begin
            drop_d = infl_d;
        end else if (resp_ok && drop_q != 2'd0) begin
            drop_d = drop_q - 2'd1;
        end
    end

    always_comb begin
        pc_F_d = pc_F_q;
        unique case (c2d_pc_sel_F)
            2'd1: pc_F_d = jr_target_D;
            2'd2: pc_F_d = jal_target_D;
            2'd3: pc_F_d = br_target_X;
            default: begin
                if (accept) begin
                    pc_F_d = pc_F_q + 32'd4;
                end
            end
        endcase
    end

    always_comb begin
        inst_D_d = inst_D_q;
        pc_D_d   = pc_D_q;
        val_D_d  = val_D_q;
        if (redirect) begin
            inst_D_d = 32'h0;
            pc_D_d   = 32'h0;
            val_D_d  = 1'b0;
        end else if (c2d_reg_en_F) begin
            if (pop) begin
                inst_D_d = buf_inst_q[buf_rd_q];
                pc_D_d   = buf_pc_q[buf_rd_q];
                val_D_d  = 1'b1;
            end else if (bypass) begin
                inst_D_d = imemresp_data;
                pc_D_d   = resp_pc;
                val_D_d  = 1'b1;
            end else begin
                inst_D_d = 32'h0;
                pc_D_d   = 32'h0;
                val_D_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_F_q   <= RESET_PC;
            infl_q   <= 2'd0;
            drop_q   <= 2'd0;
            pcq_wr_q <= 1'b0;
            pcq_rd_q <= 1'b0;
            buf_wr_q <= 1'b0;
            buf_rd_q <= 1'b0;
            occ_q    <= 2'd0;
            inst_D_q <= 32'h0;
            pc_D_q   <= 32'h0;
            val_D_q  <= 1'b0;
        end else begin
            pc_F_q   <= pc_F_d;
            infl_q   <= infl_d;
            drop_q   <= drop_d;
            inst_D_q <= inst_D_d;
            pc_D_q   <= pc_D_d;
            val_D_q  <= val_D_d;
            if (accept) begin
                pcq_wr_q <= ~pcq_wr_q;
            end
            if (resp_ok) begin
                pcq_rd_q <= ~pcq_rd_q;
            end
            // Redirect discards every buffered wrong-path instruction
            if (redirect) begin
                buf_wr_q <= 1'b0;
                buf_rd_q <= 1'b0;
                occ_q    <= 2'd0;
            end else begin
                if (push) begin
                    buf_wr_q <= ~buf_wr_q;
                end
                if (pop) begin
                    buf_rd_q <= ~buf_rd_q;
                end
                occ_q <= occ_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem_q[pcq_wr_q] <= pc_F_q;
        end
        if (push) begin
            buf_inst_q[buf_wr_q] <= imemresp_data;
            buf_pc_q[buf_wr_q]   <= resp_pc;
        end
    end

    assign inst_D     = inst_D_q;
    assign pc_D       = pc_D_q;
    assign inst_val_D = val_D_q;

endmodule
